// File: rtl/rmw_accum_if.sv
// Stream-side bundle of the keyed read-modify-write accumulator: the (key, increment)
// input stream, the drain request, the drain output stream and the busy flag.
interface rmw_accum_if #(
    parameter int KEY_BITS  = 11,
    parameter int VAL_WIDTH = 64,
    parameter int INC_WIDTH = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [KEY_BITS-1:0]  in_key;
    logic [INC_WIDTH-1:0] in_inc;
    logic                 drain_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [KEY_BITS-1:0]  out_key;
    logic [VAL_WIDTH-1:0] out_value;
    logic                 out_last;
    logic                 busy;

    // The client that feeds pairs and consumes the drain stream.
    modport master (
        output in_valid, in_key, in_inc, drain_start, out_ready,
        input  in_ready, out_valid, out_key, out_value, out_last, busy
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_key, in_inc, drain_start, out_ready,
        output in_ready, out_valid, out_key, out_value, out_last, busy
    );
endinterface

// File: rtl/rmw_accum.sv
// Keyed read-modify-write accumulator in front of a 1-cycle simple dual-port RAM, with
// write-back forwarding and a valid/ready drain. Define RMW_ACCUM_CLEAR_ON_DRAIN_EN to zero entries as they drain.
module rmw_accum #(
    parameter int KEY_BITS  = 11,
    parameter int DEPTH     = 2048,
    parameter int VAL_WIDTH = 64,
    parameter int INC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rmw_accum_if.slave           bus,
    output logic                 ram_we,
    output logic [KEY_BITS-1:0]  ram_w_addr,
    output logic [VAL_WIDTH-1:0] ram_w_data,
    output logic [KEY_BITS-1:0]  ram_r_addr,
    input  logic [VAL_WIDTH-1:0] ram_r_data
);

    typedef enum logic [2:0] {
        CLEAR,
        RUN,
        DRAIN_RD,
        DRAIN_WT,
        DRAIN_OUT
    } state_t;

    localparam logic [KEY_BITS-1:0] LAST_IDX = KEY_BITS'(DEPTH - 1);

    state_t               state;
    logic [KEY_BITS-1:0]  idx;          // clear address in CLEAR, drain address in DRAIN_*
    logic                 drain_pend;

    // Stage 1: accepted pair waiting for its RAM read data.
    logic                 v1;
    logic [KEY_BITS-1:0]  k1;
    logic [INC_WIDTH-1:0] inc1;

    // Last stage-1 write, forwarded because the RAM returns old data on a same-cycle read.
    logic                 wb_valid;
    logic [KEY_BITS-1:0]  wb_key;
    logic [VAL_WIDTH-1:0] wb_data;

    logic                 out_valid_q;
    logic [KEY_BITS-1:0]  out_key_q;
    logic [VAL_WIDTH-1:0] out_value_q;
    logic                 out_last_q;

    logic                 accept;
    logic                 upd;
    logic                 out_fire;
    logic                 idx_last;
    logic [VAL_WIDTH-1:0] base;
    logic [VAL_WIDTH-1:0] sum;

    assign bus.in_ready  = (state == RUN) && !drain_pend;
    assign bus.busy      = (state != RUN) || v1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_key   = out_key_q;
    assign bus.out_value = out_value_q;
    assign bus.out_last  = out_last_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign upd      = (state == RUN) && v1;
    assign out_fire = (state == DRAIN_OUT) && out_valid_q && bus.out_ready;
    assign idx_last = (idx == LAST_IDX);

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        base       = (wb_valid && (wb_key == k1)) ? wb_data : ram_r_data;
        sum        = base + VAL_WIDTH'(inc1);
        ram_we     = 1'b0;
        ram_w_addr = idx;
        ram_w_data = '0;
        ram_r_addr = (state == DRAIN_RD) ? idx : bus.in_key;
        if (!rst) begin
            case (state)
                CLEAR: ram_we = 1'b1;
                RUN: begin
                    if (upd) begin
                        ram_we     = 1'b1;
                        ram_w_addr = k1;
                        ram_w_data = sum;
                    end
                end
                DRAIN_OUT: begin
`ifdef RMW_ACCUM_CLEAR_ON_DRAIN_EN
                    ram_we = out_fire;
`endif
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            idx         <= '0;
            drain_pend  <= 1'b0;
            v1          <= 1'b0;
            wb_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            out_value_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            v1       <= accept;
            wb_valid <= upd;

            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx_last) begin
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.drain_start) drain_pend <= 1'b1;
                    // in_ready is already low while pending, so v1 empties within a cycle.
                    if (drain_pend && !v1) begin
                        drain_pend <= 1'b0;
                        idx        <= '0;
                        state      <= DRAIN_RD;
                    end
                end
                DRAIN_RD: state <= DRAIN_WT;
                DRAIN_WT: begin
                    out_value_q <= ram_r_data;
                    out_key_q   <= idx;
                    out_last_q  <= idx_last;
                    out_valid_q <= 1'b1;
                    state       <= DRAIN_OUT;
                end
                DRAIN_OUT: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state <= RUN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DRAIN_RD;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: payload registers qualified by v1/wb_valid need no reset; like the RAM
    // itself, their contents only matter once the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            k1   <= bus.in_key;
            inc1 <= bus.in_inc;
        end
        if (upd) begin
            wb_key  <= k1;
            wb_data <= sum;
        end
    end

endmodule

// File: tb/tb_rmw_accum.sv
// Directed bench for rmw_accum at DEPTH=16: clear sequence, accumulation with forwarding,
// wrap-around, back-pressured drains and reset in the middle of a drain.
module tb_rmw_accum;
    localparam int KEY_BITS  = 4;
    localparam int DEPTH     = 16;
    localparam int VAL_WIDTH = 16;
    localparam int INC_WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rmw_accum_if #(.KEY_BITS(KEY_BITS), .VAL_WIDTH(VAL_WIDTH), .INC_WIDTH(INC_WIDTH)) bus ();

    logic                 ram_we;
    logic [KEY_BITS-1:0]  ram_w_addr;
    logic [VAL_WIDTH-1:0] ram_w_data;
    logic [KEY_BITS-1:0]  ram_r_addr;
    logic [VAL_WIDTH-1:0] ram_r_data;

    // Simple dual-port RAM: registered read returning old data on read-during-write.
    logic [VAL_WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_w_addr] <= ram_w_data;
        ram_r_data <= mem[ram_r_addr];
    end

    rmw_accum #(
        .KEY_BITS (KEY_BITS),
        .DEPTH    (DEPTH),
        .VAL_WIDTH(VAL_WIDTH),
        .INC_WIDTH(INC_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_we    (ram_we),
        .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data),
        .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data)
    );

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;

    logic [VAL_WIDTH-1:0] model [DEPTH];
    logic [KEY_BITS-1:0]  gk [DEPTH];
    logic [VAL_WIDTH-1:0] gv [DEPTH];
    logic                 gl [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Applies one pair for exactly one cycle; called at posedge+1.
    task automatic send(input logic [KEY_BITS-1:0] k, input logic [INC_WIDTH-1:0] inc);
        bus.in_valid = 1'b1;
        bus.in_key   = k;
        bus.in_inc   = inc;
        if (bus.in_ready !== 1'b1) stalls++;
        model[k] = model[k] + VAL_WIDTH'(inc);
        step();
    endtask

    // Called at posedge+1 right after rst is released.
    task automatic wait_clear(input string tag);
        int  n_we;
        int  n;
        int  bad;
        bit  done;
        n_we = 0;
        n    = 0;
        bad  = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                if (ram_we === 1'b1) begin
                    if (ram_w_addr !== KEY_BITS'(n_we) || ram_w_data !== '0) bad++;
                    n_we++;
                end
                if (bus.busy !== 1'b1) bad++;
                n++;
            end
        end
        check({tag, " clear writes"}, n_we, 16);
        check({tag, " clear cycles"}, n, 16);
        check({tag, " clear addr/data/busy errors"}, bad, 0);
        check({tag, " in_ready after clear"}, done, 1);
        check({tag, " busy after clear"}, bus.busy, 0);
        zero_model();
        step();
    endtask

    // mode 0: out_ready always high; mode 1: high one cycle in three.
    task automatic drain(input int mode, input string tag);
        int                   got;
        int                   cyc;
        int                   unstable;
        bit                   hold;
        logic [KEY_BITS-1:0]  hk;
        logic [VAL_WIDTH-1:0] hv;
        logic                 hl;
        got      = 0;
        cyc      = 0;
        unstable = 0;
        hold     = 1'b0;
        hk       = '0;
        hv       = '0;
        hl       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            gk[i] = 'x;
            gv[i] = 'x;
            gl[i] = 1'bx;
        end
        bus.in_valid    = 1'b0;
        bus.drain_start = 1'b1;
        step();
        bus.drain_start = 1'b0;
        check({tag, " in_ready while draining"}, bus.in_ready, 0);
        while (got < DEPTH && cyc < 600) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (hold && (bus.out_key !== hk || bus.out_value !== hv || bus.out_last !== hl))
                    unstable++;
                if (bus.out_ready) begin
                    gk[got] = bus.out_key;
                    gv[got] = bus.out_value;
                    gl[got] = bus.out_last;
                    got++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hk   = bus.out_key;
                    hv   = bus.out_value;
                    hl   = bus.out_last;
                end
            end
            step();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check({tag, " entries drained"}, got, DEPTH);
        check({tag, " output changed while stalled"}, unstable, 0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s key[%0d]", tag, i), gk[i], i);
            check($sformatf("%s value[%0d]", tag, i), gv[i], model[i]);
            check($sformatf("%s last[%0d]", tag, i), gl[i], (i == DEPTH - 1) ? 1 : 0);
        end
        check({tag, " busy after drain"}, bus.busy, 0);
        check({tag, " in_ready after drain"}, bus.in_ready, 1);
`ifdef RMW_ACCUM_CLEAR_ON_DRAIN_EN
        zero_model();
`endif
    endtask

    initial begin
        bit found;
        int n;

        bus.in_valid    = 1'b0;
        bus.in_key      = '0;
        bus.in_inc      = '0;
        bus.drain_start = 1'b0;
        bus.out_ready   = 1'b0;
        zero_model();

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset out_key", bus.out_key, 0);
        check("reset out_value", bus.out_value, 0);
        check("reset ram_we", ram_we, 0);
        check("reset busy", bus.busy, 1);
        step();
        rst = 1'b0;
        wait_clear("por");

        // Spaced same-key hits, then a full-speed drain.
        send(4'd3, 8'd5);
        send(4'd7, 8'd2);
        send(4'd3, 8'd1);
        drain(0, "d1");
        check("d1 entry3 const", gv[3], 16'd6);
        check("d1 entry7 const", gv[7], 16'd2);

        // Back-to-back same-key runs exercise forwarding every cycle; entry 2 wraps.
        for (int i = 0; i < 5; i++) send(4'd9, 8'd255);
        for (int i = 0; i < 257; i++) send(4'd2, 8'd255);
        send(4'd2, 8'd3);
        drain(1, "d2");
        check("d2 entry9 const", gv[9], 16'd1275);
        check("d2 entry2 wrap const", gv[2], 16'h0002);

        // Second drain: persistent values, or all zeros when clear-on-drain is built in.
        drain(0, "d3");
`ifdef RMW_ACCUM_CLEAR_ON_DRAIN_EN
        check("d3 entry9 const", gv[9], 16'd0);
`else
        check("d3 entry9 const", gv[9], 16'd1275);
`endif

        // Reset in the middle of a drain, once entry 6 is on the output.
        send(4'd6, 8'd10);
        send(4'd15, 8'd1);
        bus.in_valid    = 1'b0;
        bus.drain_start = 1'b1;
        step();
        bus.drain_start = 1'b0;
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_key === 4'd6) found = 1'b1;
            step();
            n++;
        end
        check("mid-drain idx 6 reached", found, 1);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        step();
        @(negedge clk);
        check("mid-drain rst out_valid", bus.out_valid, 0);
        check("mid-drain rst ram_we", ram_we, 0);
        check("mid-drain rst busy", bus.busy, 1);
        step();
        rst = 1'b0;
        wait_clear("rst");
        drain(0, "d4");
        check("d4 entry6 const", gv[6], 16'd0);

        check("input stalls during bursts", stalls, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
